vector_mem_seq: RTL and testbench
=================================

VECTOR_MEM_SEQ -- requirements
Module: vector_mem_seq

Interface
REQ-001 The block SHALL have parameter NLANE, default 16, meaning the number of 16-bit lanes per vector; vector width is 16*NLANE.
REQ-002 The block SHALL have parameter AW, default 16, meaning the memory word-address width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port start, input, 1 bit: command request, sampled only in IDLE.
REQ-007 Port opcode, input, 4 bits: 4'b0100 = VLD, 4'b0101 = VST; any other value is invalid.
REQ-008 Port base_addr, input, AW bits: effective address, i.e. the ALU result bits [15:0].
REQ-009 Port st_data, input, 16*NLANE bits: vector to store, captured at command accept.
REQ-010 Port mem_addr, output, AW bits: word address of the current access.
REQ-011 Port mem_re, output, 1 bit: read strobe.
REQ-012 Port mem_we, output, 1 bit: write strobe.
REQ-013 Port mem_wdata, output, 16 bits: store word.
REQ-014 Port mem_rdata, input, 16 bits: read word, valid when mem_rdy=1 with mem_re=1.
REQ-015 Port mem_rdy, input, 1 bit: memory accepts or completes the current access this cycle.
REQ-016 Port ld_data, output, 16*NLANE bits: assembled load vector.
REQ-017 Port busy, output, 1 bit: high in every state except IDLE.
REQ-018 Port done, output, 1 bit: one-cycle completion pulse.
REQ-019 Port err, output, 1 bit: one-cycle pulse on an invalid opcode.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, STORE and FIN.
REQ-021 In IDLE, start=1 with VLD SHALL latch base_addr, clear lane counter cnt to 0, and go to LOAD.
REQ-022 In IDLE, start=1 with VST SHALL latch base_addr and st_data, clear cnt to 0, and go to STORE.
REQ-023 In IDLE, start=1 with any other opcode SHALL pulse err for the next cycle and remain in IDLE.
REQ-024 start SHALL be ignored outside IDLE; no queuing and no err.
REQ-025 In LOAD, the block SHALL drive mem_re=1 and mem_addr=(base+cnt) mod 2^AW, with address wrap-around permitted.
REQ-026 In LOAD, when mem_rdy=1, the block SHALL write mem_rdata into ld_data[16*cnt+15:16*cnt].
REQ-027 In STORE, the block SHALL drive mem_we=1, mem_addr=(base+cnt) mod 2^AW, and mem_wdata=latched st_data lane cnt.
REQ-028 In LOAD or STORE, mem_rdy=0 SHALL hold cnt, mem_addr and the strobes unchanged (wait state, unbounded).
REQ-029 In LOAD or STORE, mem_rdy=1 with cnt<NLANE-1 SHALL increment cnt; mem_rdy=1 with cnt=NLANE-1 SHALL go to FIN.
REQ-030 mem_re and mem_we SHALL never be high simultaneously, and both SHALL be 0 outside LOAD and STORE.
REQ-031 In FIN, the block SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-032 In FIN, a start arriving in the FIN cycle SHALL be ignored.
REQ-033 Latency with mem_rdy held at 1 SHALL be: start accepted in cycle 0, accesses in cycles 1..NLANE, done in cycle NLANE+1, and the next start accepted in cycle NLANE+2.
REQ-034 Lane ordering SHALL be: lane i at address base+i, occupying bits [16i+15:16i].
REQ-035 ld_data SHALL retain its value after done until the next VLD overwrites it lane by lane; VST SHALL not modify ld_data.
REQ-036 Changes on st_data or base_addr after accept SHALL have no effect on the command in flight.

Reset
REQ-037 rst=1 at a clock edge SHALL force IDLE, with cnt=0, mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, ld_data=0, busy=0, done=0 and err=0.
REQ-038 Reset SHALL take priority over start and over mem_rdy.
REQ-039 Reset mid-LOAD or mid-STORE SHALL abort the command, drop the strobes at the same edge, and produce no done.

Verification
REQ-040 VLD scenario: base=0x0100, mem_rdy=1, memory word at address a = a.
  - Required: 16 reads at 0x0100..0x010F.
  - Required: done in cycle 17 with ld_data lane i = 0x0100+i.
REQ-041 VST scenario: base=0x0200, st_data lane i = 0xA000+i.
  - Required: 16 writes with mem_addr=0x0200+i and mem_wdata=0xA000+i.
  - Required: done pulse, ld_data unchanged.
REQ-042 Wrap-around scenario: VLD with base=0xFFFE.
  - Required: addresses 0xFFFE, 0xFFFF, 0x0000 .. 0x000D.
REQ-043 Wait-state scenario: VST with mem_rdy=0 for 3 cycles at lane 5.
  - Required: address and data held at lane 5 during the wait.
  - Required: done in cycle 20.
REQ-044 Invalid/busy scenario: start with opcode 4'b0000.
  - Required: err pulse, busy stays 0.
  - Also: start during LOAD is ignored and only one done is produced.
REQ-045 Reset scenario: rst asserted while cnt=7 in LOAD.
  - Required: next cycle busy=0, mem_re=0, ld_data=0, and no done.
  - Required: a subsequent VLD completes normally.

Source files
------------

// File: rtl/vector_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vector_mem_seq
//  Description : Vector load/store sequencer. Moves NLANE 16-bit lanes between
//                a word-addressed memory and a wide vector, one lane per
//                accepted memory access, lane i at address base+i.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_mem_seq #(
   parameter int NLANE = 16,
   parameter int AW    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [3:0]            opcode,
   input  logic [AW-1:0]         base_addr,
   input  logic [16*NLANE-1:0]   st_data,
   output logic [AW-1:0]         mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [15:0]           mem_wdata,
   input  logic [15:0]           mem_rdata,
   input  logic                  mem_rdy,
   output logic [16*NLANE-1:0]   ld_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   // Lane counter width; a single-lane build still needs one counter bit.
   localparam int              CW        = (NLANE > 1) ? $clog2(NLANE) : 1;
   localparam logic [CW-1:0]   LAST_LANE = CW'(NLANE - 1);
   localparam logic [3:0]      OP_VLD    = 4'b0100;
   localparam logic [3:0]      OP_VST    = 4'b0101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   // Vectors are held lane-indexed so the current lane is a plain array select.
   typedef logic [NLANE-1:0][15:0] vec_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic [AW-1:0]     base_q,  base_d;
   vec_t              st_q,    st_d;
   vec_t              ld_q,    ld_d;
   logic [AW-1:0]     addr_q,  addr_d;
   logic              re_q,    re_d;
   logic              we_q,    we_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              err_q,   err_d;

   logic [CW-1:0]     cnt_inc;
   logic              last_lane;

   assign cnt_inc   = cnt_q + 1'b1;
   assign last_lane = (cnt_q == LAST_LANE);

   // Next-state and next-output computation; every output is registered so the
   // memory sees clean strobes and the address for lane cnt during its access.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      st_d    = st_q;
      ld_d    = ld_q;
      addr_d  = addr_q;
      re_d    = re_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (opcode == OP_VLD) begin
                  state_d = ST_LOAD;
                  base_d  = base_addr;
                  cnt_d   = '0;
                  addr_d  = base_addr;
                  re_d    = 1'b1;
                  we_d    = 1'b0;
                  busy_d  = 1'b1;
               end else if (opcode == OP_VST) begin
                  state_d = ST_STORE;
                  base_d  = base_addr;
                  st_d    = st_data;
                  cnt_d   = '0;
                  addr_d  = base_addr;
                  wdata_d = st_data[15:0];
                  re_d    = 1'b0;
                  we_d    = 1'b1;
                  busy_d  = 1'b1;
               end else begin
                  // Rejected command: flag it and stay idle.
                  err_d = 1'b1;
               end
            end
         end

         ST_LOAD: begin
            // mem_rdy low is a wait state: nothing changes.
            if (mem_rdy) begin
               ld_d[cnt_q] = mem_rdata;
               if (last_lane) begin
                  state_d = ST_FIN;
                  cnt_d   = '0;
                  addr_d  = '0;
                  re_d    = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d  = cnt_inc;
                  addr_d = base_q + AW'(cnt_inc);
               end
            end
         end

         ST_STORE: begin
            if (mem_rdy) begin
               if (last_lane) begin
                  state_d = ST_FIN;
                  cnt_d   = '0;
                  addr_d  = '0;
                  wdata_d = '0;
                  we_d    = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d   = cnt_inc;
                  addr_d  = base_q + AW'(cnt_inc);
                  wdata_d = st_q[cnt_inc];
               end
            end
         end

         ST_FIN: begin
            // done is high during this cycle; any start here is dropped.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            re_d    = 1'b0;
            we_d    = 1'b0;
            wdata_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset wins over start and mem_rdy and aborts
   // any command in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         st_q    <= '0;
         ld_q    <= '0;
         addr_q  <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         st_q    <= st_d;
         ld_q    <= ld_d;
         addr_q  <= addr_d;
         re_q    <= re_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_re    = re_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;
   assign ld_data   = ld_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_mem_seq
//  Description : Self-checking bench for vector_mem_seq with a word memory
//                model and a lane-level reference of every command.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_mem_seq;

   localparam int         NLANE  = 16;
   localparam int         AW     = 16;
   localparam int         VW     = 16 * NLANE;
   localparam logic [3:0] OP_VLD = 4'b0100;
   localparam logic [3:0] OP_VST = 4'b0101;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [3:0]      opcode = '0;
   logic [AW-1:0]   base_addr = '0;
   logic [VW-1:0]   st_data = '0;
   logic [AW-1:0]   mem_addr;
   logic            mem_re;
   logic            mem_we;
   logic [15:0]     mem_wdata;
   logic [15:0]     mem_rdata;
   logic            mem_rdy = 1'b0;
   logic [VW-1:0]   ld_data;
   logic            busy;
   logic            done;
   logic            err;

   int              checks = 0;
   int              errors = 0;

   // Memory model: unwritten words read as (address ^ salt).
   logic            clr_mem = 1'b1;
   logic [15:0]     salt = '0;
   bit              written [0:65535];
   logic [15:0]     wmem    [0:65535];
   logic [VW-1:0]   exp_ld = '0;

   vector_mem_seq #(.NLANE(NLANE), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .opcode    (opcode),
      .base_addr (base_addr),
      .st_data   (st_data),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy),
      .ld_data   (ld_data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd_word(input logic [15:0] a);
      return written[a] ? wmem[a] : (a ^ salt);
   endfunction

   function automatic logic [15:0] lane_of(input logic [VW-1:0] v, input int i);
      logic [VW-1:0] t;
      t = v >> (16 * i);
      return t[15:0];
   endfunction

   assign mem_rdata = rd_word(mem_addr);

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int a = 0; a < 65536; a++) written[a] <= 1'b0;
      end else if (mem_we && mem_rdy) begin
         written[mem_addr] <= 1'b1;
         wmem[mem_addr]    <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < NLANE; i++) v = (v << 16) | VW'($urandom_range(0, 65535));
      return v;
   endfunction

   // Issue one command and follow it cycle by cycle. Cycle numbering: the
   // accept cycle is 0, the first negedge after the accepting edge is cycle 1.
   task automatic run_cmd(input logic [3:0] op, input logic [15:0] base,
                          input logic [VW-1:0] vec, input int stall_lane,
                          input int stall_n, input bit rnd_stall, input bit poke,
                          input int abort_lane);
      int            lane, cyc, stalls, waited;
      bit            r;
      logic [VW-1:0] exp_vec;
      logic [15:0]   a;
      exp_vec = '0;
      for (int i = 0; i < NLANE; i++)
         exp_vec = exp_vec | (VW'(rd_word(16'(base + 16'(i)))) << (16 * i));
      start = 1'b1; opcode = op; base_addr = base; st_data = vec;
      @(negedge clk);
      start = 1'b0;
      base_addr = 16'($urandom);
      st_data   = rand_vec();
      lane = 0; cyc = 1; stalls = 0; waited = 0;
      while (lane < NLANE) begin
         if (cyc > 300) begin
            chk("timeout_lanes", VW'(lane), VW'(NLANE));
            return;
         end
         a = 16'(base + 16'(lane));
         chk("busy_active", VW'(busy), VW'(1));
         chk("done_early", VW'(done), VW'(0));
         chk("mem_re", VW'(mem_re), VW'(op == OP_VLD));
         chk("mem_we", VW'(mem_we), VW'(op == OP_VST));
         chk("mem_addr", VW'(mem_addr), VW'(a));
         if (op == OP_VST) chk("mem_wdata", VW'(mem_wdata), VW'(lane_of(vec, lane)));
         if (lane == abort_lane) begin
            rst = 1'b1; mem_rdy = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_busy", VW'(busy), VW'(0));
            chk("abort_re", VW'(mem_re), VW'(0));
            chk("abort_we", VW'(mem_we), VW'(0));
            chk("abort_ld", ld_data, VW'(0));
            chk("abort_done", VW'(done), VW'(0));
            exp_ld = '0;
            repeat (3) begin
               @(negedge clk);
               chk("abort_no_done", VW'(done), VW'(0));
               chk("abort_idle", VW'(busy), VW'(0));
            end
            return;
         end
         start  = poke && (lane == 3);
         opcode = OP_VST;
         if (lane == stall_lane && waited < stall_n) begin
            r = 1'b0; waited++;
         end else if (rnd_stall) begin
            r = ($urandom_range(0, 3) != 0);
         end else begin
            r = 1'b1;
         end
         mem_rdy = r;
         if (r) lane++; else stalls++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("done_pulse", VW'(done), VW'(1));
      chk("done_cycle", VW'(cyc), VW'(NLANE + 1 + stalls));
      chk("fin_busy", VW'(busy), VW'(1));
      chk("fin_strobes", VW'({mem_re, mem_we}), VW'(0));
      if (op == OP_VLD) exp_ld = exp_vec;
      mem_rdy = 1'($urandom);
      if (poke) begin start = 1'b1; opcode = OP_VLD; end
      @(negedge clk);
      start = 1'b0;
      chk("done_once", VW'(done), VW'(0));
      chk("idle_busy", VW'(busy), VW'(0));
      chk("idle_err", VW'(err), VW'(0));
      chk("ld_data", ld_data, exp_ld);
      if (op == OP_VST)
         for (int i = 0; i < NLANE; i++)
            chk("mem_stored", VW'(rd_word(16'(base + 16'(i)))), VW'(lane_of(vec, i)));
      if (poke) begin
         @(negedge clk);
         chk("fin_start_ignored", VW'(busy), VW'(0));
      end
   endtask

   task automatic bad_cmd(input logic [3:0] op);
      start = 1'b1; opcode = op;
      @(negedge clk);
      start = 1'b0;
      chk("err_pulse", VW'(err), VW'(1));
      chk("err_busy", VW'(busy), VW'(0));
      chk("err_strobes", VW'({mem_re, mem_we}), VW'(0));
      @(negedge clk);
      chk("err_clear", VW'(err), VW'(0));
      chk("err_still_idle", VW'(busy), VW'(0));
   endtask

   initial begin
      logic [VW-1:0] v;
      logic [3:0]    op;
      // Reset state.
      rst = 1'b1; clr_mem = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_addr", VW'(mem_addr), VW'(0));
      chk("rst_strobes", VW'({mem_re, mem_we}), VW'(0));
      chk("rst_wdata", VW'(mem_wdata), VW'(0));
      chk("rst_ld", ld_data, VW'(0));
      chk("rst_flags", VW'({busy, done, err}), VW'(0));
      rst = 1'b0; clr_mem = 1'b0;
      @(negedge clk);

      // Load from 0x0100 with identity memory contents.
      salt = 16'h0000;
      run_cmd(OP_VLD, 16'h0100, '0, -1, 0, 1'b0, 1'b0, -1);
      for (int i = 0; i < NLANE; i++)
         chk("vld_lane", VW'(lane_of(ld_data, i)), VW'(16'h0100 + 16'(i)));

      // Store A000+i at 0x0200; ld_data must not move.
      v = '0;
      for (int i = 0; i < NLANE; i++) v = v | (VW'(16'hA000 + 16'(i)) << (16 * i));
      run_cmd(OP_VST, 16'h0200, v, -1, 0, 1'b0, 1'b0, -1);

      // Address wrap-around.
      run_cmd(OP_VLD, 16'hFFFE, '0, -1, 0, 1'b0, 1'b0, -1);

      // Three wait states at lane 5 of a store.
      run_cmd(OP_VST, 16'(16'h3000 + 16'($urandom_range(0, 255))), rand_vec(), 5, 3, 1'b0, 1'b0, -1);

      // Invalid opcode, then start pokes during LOAD and in FIN.
      bad_cmd(4'b0000);
      run_cmd(OP_VLD, 16'h0200, '0, -1, 0, 1'b0, 1'b1, -1);

      // Reset while lane 7 of a load is in flight, then a clean load.
      salt = 16'h5A5A;
      run_cmd(OP_VLD, 16'h4000, '0, -1, 0, 1'b0, 1'b0, 7);
      run_cmd(OP_VLD, 16'h4000, '0, -1, 0, 1'b0, 1'b0, -1);

      // Randomized commands with random wait states.
      for (int k = 0; k < 10; k++) begin
         salt = 16'($urandom);
         op   = $urandom_range(0, 1) ? OP_VLD : OP_VST;
         run_cmd(op, 16'($urandom), rand_vec(), -1, 0, 1'b1, 1'b0, -1);
         if (k % 4 == 3) begin
            op = 4'($urandom_range(6, 15));
            bad_cmd(op);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
